div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arb_pkg.sv | 27 ++
 rtl/rr_arbiter_2.sv | 16 +
 rtl/div_arbiter.sv | 170 +++++++++++++++++
 tb/tb_div_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the two-port divider arbiter.
package div_arb_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    localparam logic [DATA_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] INT_MIN      = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESPOND
    } state_t;

    // INT_MIN / -1 cannot be represented; the arbiter answers it directly.
    function automatic logic is_signed_overflow(input logic              sgn,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sb;
        sb = $signed(b);
        return sgn && (a == INT_MIN) && (sb == -1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant: a lone requester wins, a tie goes to the
// port that was not served last.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external iterative divider between two request ports, answering
// divide-by-zero and signed overflow locally and timing out a silent divider.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int WAIT_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_signed,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*TAG_W-1:0]  req_tag,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_q,
    output logic [DATA_W-1:0]   rsp_r,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_dbz,
    output logic                rsp_err,
    output logic                div_start,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_a,
    output logic [DATA_W-1:0]   div_b,
    input  logic                div_busy,
    input  logic [DATA_W-1:0]   div_q,
    input  logic [DATA_W-1:0]   div_r
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    state_t state, state_nx;

    logic [1:0]        grant;
    logic              last;
    logic              accept;
    logic              sel_port;
    logic              sel_signed;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [TAG_W-1:0]  sel_tag;

    logic              op_port, op_signed;
    logic [DATA_W-1:0] op_a, op_b;
    logic [TAG_W-1:0]  op_tag;
    logic [CNT_W-1:0]  wait_cnt;

    logic              res_load;
    logic [DATA_W-1:0] res_q, res_r, res_q_nx, res_r_nx;
    logic              res_dbz, res_err, res_dbz_nx, res_err_nx;

    rr_arbiter_2 u_rr (
        .valid (req_valid),
        .last  (last),
        .grant (grant)
    );

    assign sel_port   = grant[1];
    assign sel_signed = sel_port ? req_signed[1] : req_signed[0];
    assign sel_a      = sel_port ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
    assign sel_b      = sel_port ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
    assign sel_tag    = sel_port ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
    assign accept     = (state == IDLE) && (grant != 2'b00);

    // State is already IDLE under reset; gating keeps req_ready low meanwhile.
    assign req_ready  = (state == IDLE && !reset) ? grant : 2'b00;
    assign rsp_valid  = (state == RESPOND) ? (op_port ? 2'b10 : 2'b01) : 2'b00;
    assign div_start  = (state == START);
    assign div_a      = op_a;
    assign div_b      = op_b;
    assign div_signed = op_signed;
    assign rsp_q      = res_q;
    assign rsp_r      = res_r;
    assign rsp_tag    = op_tag;
    assign rsp_dbz    = res_dbz;
    assign rsp_err    = res_err;

    always_comb begin
        state_nx   = state;
        res_load   = 1'b0;
        res_q_nx   = '0;
        res_r_nx   = '0;
        res_dbz_nx = 1'b0;
        res_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    res_load = 1'b1;
                    if (sel_b == '0) begin
                        state_nx   = RESPOND;
                        res_q_nx   = DBZ_QUOTIENT;
                        res_r_nx   = sel_a;
                        res_dbz_nx = 1'b1;
                    end else if (is_signed_overflow(sel_signed, sel_a, sel_b)) begin
                        state_nx = RESPOND;
                        res_q_nx = INT_MIN;
                    end else begin
                        state_nx = START;
                    end
                end
            end
            START: state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (div_busy) begin
                    state_nx = WAIT_DONE;
                end else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                    state_nx   = RESPOND;
                    res_load   = 1'b1;
                    res_err_nx = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!div_busy) begin
                    state_nx = RESPOND;
                    res_load = 1'b1;
                    res_q_nx = div_q;
                    res_r_nx = div_r;
                end
            end
            RESPOND: begin
                if (rsp_ready[op_port]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            op_port   <= 1'b0;
            op_signed <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_tag    <= '0;
            wait_cnt  <= '0;
            res_q     <= '0;
            res_r     <= '0;
            res_dbz   <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_port   <= sel_port;
                op_signed <= sel_signed;
                op_a      <= sel_a;
                op_b      <= sel_b;
                op_tag    <= sel_tag;
            end
            if (res_load) begin
                res_q   <= res_q_nx;
                res_r   <= res_r_nx;
                res_dbz <= res_dbz_nx;
                res_err <= res_err_nx;
            end
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT_BUSY) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == RESPOND && rsp_ready[op_port]) begin
                last <= op_port;
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a small multi-cycle divider stub.
module tb_div_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_signed;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_tag;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_q, rsp_r;
    logic [3:0]  rsp_tag;
    logic        rsp_dbz, rsp_err;
    logic        div_start, div_signed, div_busy;
    logic [31:0] div_a, div_b, div_q, div_r;

    logic        div_dead;
    int          starts;
    int          nchk = 0;
    int          nerr = 0;

    div_arbiter #(.WAIT_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_q      (rsp_q),
        .rsp_r      (rsp_r),
        .rsp_tag    (rsp_tag),
        .rsp_dbz    (rsp_dbz),
        .rsp_err    (rsp_err),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_busy   (div_busy),
        .div_q      (div_q),
        .div_r      (div_r)
    );

    always #5 clk = ~clk;

    // Divider stub: busy for three cycles after start, unless held dead.
    logic signed [31:0] sq, sr;
    logic [1:0]         busy_cnt;
    assign sq = $signed(div_a) / $signed(div_b);
    assign sr = $signed(div_a) % $signed(div_b);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            div_busy <= 1'b0;
            busy_cnt <= 2'd0;
            div_q    <= 32'd0;
            div_r    <= 32'd0;
            starts   <= 0;
        end else begin
            if (div_start) starts <= starts + 1;
            if (div_start && !div_dead) begin
                div_busy <= 1'b1;
                busy_cnt <= 2'd3;
                div_q    <= div_signed ? sq : div_a / div_b;
                div_r    <= div_signed ? sr : div_a % div_b;
            end else if (busy_cnt != 2'd0) begin
                busy_cnt <= busy_cnt - 2'd1;
                if (busy_cnt == 2'd1) div_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
        req_valid[p]       = 1'b1;
        req_signed[p]      = s;
        req_a[32*p +: 32]  = a;
        req_b[32*p +: 32]  = b;
        req_tag[4*p +: 4]  = t;
    endtask

    task automatic wait_ready(input string tag, input logic [1:0] exp);
        int n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant"}, 32'(req_ready), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int n = 0;
        @(negedge clk);
        while (rsp_valid == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] v, input logic [31:0] q,
                           input logic [31:0] r, input logic [3:0] t,
                           input logic dbz, input logic err);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, "_q"}, rsp_q, q);
        chk({tag, "_r"}, rsp_r, r);
        chk({tag, "_tag"}, 32'(rsp_tag), 32'(t));
        chk({tag, "_dbz"}, 32'(rsp_dbz), 32'(dbz));
        chk({tag, "_err"}, 32'(rsp_err), 32'(err));
    endtask

    task automatic ack(input int p);
        rsp_ready[p] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[p] = 1'b0;
    endtask

    task automatic op(input string tag, input int p, input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] t, input int lat,
                      input logic [31:0] q, input logic [31:0] r, input logic dbz,
                      input logic err, input int nstart);
        int s0;
        s0 = starts;
        drive(p, s, a, b, t);
        wait_ready(tag, (p == 1) ? 2'b10 : 2'b01);
        req_valid[p] = 1'b0;
        wait_rsp(tag, lat);
        chk_rsp(tag, (p == 1) ? 2'b10 : 2'b01, q, r, t, dbz, err);
        chk({tag, "_starts"}, 32'(starts - s0), 32'(nstart));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset      = 1'b1;
        div_dead   = 1'b0;
        rsp_ready  = 2'b00;
        req_valid  = 2'b00;
        req_signed = 2'b00;
        req_a      = 64'd0;
        req_b      = 64'd0;
        req_tag    = 8'd0;
        drive(0, 1'b0, 32'd10, 32'd3, 4'd1);
        drive(1, 1'b0, 32'd20, 32'd4, 4'd2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_div_start", 32'(div_start), 32'd0);
        chk("reset_div_a", div_a, 32'd0);
        chk("reset_div_b", div_b, 32'd0);
        chk("reset_div_signed", 32'(div_signed), 32'd0);
        chk("reset_rsp_q", rsp_q, 32'd0);
        chk("reset_rsp_r", rsp_r, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Both ports held valid: 0, then 1, then 0 again.
        wait_ready("rr1", 2'b01);
        wait_rsp("rr1", 5);
        chk_rsp("rr1", 2'b01, 32'd3, 32'd1, 4'd1, 1'b0, 1'b0);
        chk("rr_ready_while_busy", 32'(req_ready), 32'd0);
        ack(0);
        wait_ready("rr2", 2'b10);
        wait_rsp("rr2", 5);
        chk_rsp("rr2", 2'b10, 32'd5, 32'd0, 4'd2, 1'b0, 1'b0);
        ack(1);
        wait_ready("rr3", 2'b01);
        req_valid = 2'b00;
        wait_rsp("rr3", 5);
        chk_rsp("rr3", 2'b01, 32'd3, 32'd1, 4'd1, 1'b0, 1'b0);
        ack(0);

        op("u7d2", 0, 1'b0, 32'd7, 32'd2, 4'd3, 5, 32'd3, 32'd1, 1'b0, 1'b0, 1);
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        chk("wrong_port_ack_valid", 32'(rsp_valid), 32'(2'b01));
        chk("wrong_port_ack_q", rsp_q, 32'd3);
        ack(0);

        op("sm7d2", 1, 1'b1, 32'hFFFF_FFF9, 32'd2, 4'd5, 5,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        ack(1);

        op("dbz", 0, 1'b0, 32'd5, 32'd0, 4'd7, 0,
           32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 0);
        ack(0);

        op("sovf", 1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 0,
           32'h8000_0000, 32'd0, 1'b0, 1'b0, 0);
        ack(1);

        op("uovf", 1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 5,
           32'd0, 32'h8000_0000, 1'b0, 1'b0, 1);
        ack(1);

        div_dead = 1'b1;
        op("tmo", 0, 1'b0, 32'd100, 32'd7, 4'd6, 5, 32'd0, 32'd0, 1'b0, 1'b1, 1);
        ack(0);
        div_dead = 1'b0;

        // Reset while the divider is running.
        drive(1, 1'b0, 32'd100, 32'd7, 4'hA);
        wait_ready("rst", 2'b10);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 32'(div_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen = 1'b1;
        end
        chk("rst_no_response", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        op("post_rst", 0, 1'b0, 32'd100, 32'd7, 4'hB, 5, 32'd14, 32'd2, 1'b0, 1'b0, 1);
        ack(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
